// File: rtl/game_mode_ctrl.sv
// Match sequencer: title screen, mode latch, round scoring and frame-paced round/match pauses.
// All outputs are registered; VGA_VS is synchronised and edge-detected into a one-cycle frame tick.
module game_mode_ctrl #(
  parameter int unsigned WIN_ROUNDS  = 2,
  parameter int unsigned HOLD_FRAMES = 120,
  parameter logic [7:0]  KEY_SINGLE  = 8'h1E,
  parameter logic [7:0]  KEY_DUEL    = 8'h1F,
  parameter logic [7:0]  KEY_ENTER   = 8'h28,
  parameter logic [7:0]  KEY_ESC     = 8'h29
) (
  input  logic        Clk,
  input  logic        Reset_h,
  input  logic        VGA_VS,
  input  logic [15:0] keycode,
  input  logic        p1win,
  input  logic        p2win,
  output logic        du,
  output logic        sin,
  output logic        st,
  output logic        round_rst,
  output logic [1:0]  p1_score,
  output logic [1:0]  p2_score,
  output logic        match_over,
  output logic        winner
);

  typedef enum logic [1:0] {
    TITLE,
    FIGHT,
    ROUND_END,
    MATCH_END
  } state_t;

  localparam logic [1:0] WIN_SCORE = 2'(WIN_ROUNDS);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

  localparam int unsigned K_SINGLE = 0;
  localparam int unsigned K_DUEL   = 1;
  localparam int unsigned K_ENTER  = 2;
  localparam int unsigned K_ESC    = 3;

  logic       vs_s1_q, vs_s2_q, vs_s3_q, tick_q;
  logic [3:0] key_now, key_q, key_press;

  state_t     state_q, state_d;
  logic       du_q, du_d, sin_q, sin_d, rr_q, rr_d;
  logic       winner_q, winner_d, st_q, mo_q;
  logic [1:0] p1_q, p1_d, p2_q, p2_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    key_now           = '0;
    key_now[K_SINGLE] = (keycode[7:0] == KEY_SINGLE) || (keycode[15:8] == KEY_SINGLE);
    key_now[K_DUEL]   = (keycode[7:0] == KEY_DUEL)   || (keycode[15:8] == KEY_DUEL);
    key_now[K_ENTER]  = (keycode[7:0] == KEY_ENTER)  || (keycode[15:8] == KEY_ENTER);
    key_now[K_ESC]    = (keycode[7:0] == KEY_ESC)    || (keycode[15:8] == KEY_ESC);
    key_press         = key_now & ~key_q;
  end

  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      vs_s1_q <= 1'b0;
      vs_s2_q <= 1'b0;
      vs_s3_q <= 1'b0;
      tick_q  <= 1'b0;
      key_q   <= '0;
    end else begin
      vs_s1_q <= VGA_VS;
      vs_s2_q <= vs_s1_q;
      vs_s3_q <= vs_s2_q;
      tick_q  <= vs_s2_q & ~vs_s3_q;
      key_q   <= key_now;
    end
  end

  always_comb begin
    state_d  = state_q;
    du_d     = du_q;
    sin_d    = sin_q;
    rr_d     = 1'b0;
    p1_d     = p1_q;
    p2_d     = p2_q;
    winner_d = winner_q;
    cnt_d    = cnt_q;
    // Abort outranks every other event, including a terminal frame tick.
    if (state_q != TITLE && key_press[K_ESC]) begin
      state_d  = TITLE;
      du_d     = 1'b0;
      sin_d    = 1'b0;
      p1_d     = '0;
      p2_d     = '0;
      winner_d = 1'b0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        TITLE: begin
          p1_d = '0;
          p2_d = '0;
          if (key_press[K_SINGLE]) begin
            sin_d   = 1'b1;
            du_d    = 1'b0;
            state_d = FIGHT;
            rr_d    = 1'b1;
          end else if (key_press[K_DUEL]) begin
            du_d    = 1'b1;
            sin_d   = 1'b0;
            state_d = FIGHT;
            rr_d    = 1'b1;
          end
        end
        FIGHT: begin
          if (p1win || p2win) begin
            state_d = ROUND_END;
            cnt_d   = '0;
            if (p1win && !p2win && p1_q < WIN_SCORE) p1_d = p1_q + 2'd1;
            if (p2win && !p1win && p2_q < WIN_SCORE) p2_d = p2_q + 2'd1;
          end
        end
        ROUND_END: begin
          if (tick_q) begin
            if (cnt_q == HOLD_LAST) begin
              if (p1_q == WIN_SCORE || p2_q == WIN_SCORE) begin
                state_d  = MATCH_END;
                winner_d = (p2_q == WIN_SCORE);
              end else begin
                state_d = FIGHT;
                rr_d    = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        MATCH_END: begin
          if (key_press[K_ENTER]) begin
            state_d  = TITLE;
            du_d     = 1'b0;
            sin_d    = 1'b0;
            p1_d     = '0;
            p2_d     = '0;
            winner_d = 1'b0;
          end
        end
        default: state_d = TITLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      state_q  <= TITLE;
      du_q     <= 1'b0;
      sin_q    <= 1'b0;
      rr_q     <= 1'b0;
      p1_q     <= '0;
      p2_q     <= '0;
      winner_q <= 1'b0;
      cnt_q    <= '0;
      st_q     <= 1'b1;
      mo_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      du_q     <= du_d;
      sin_q    <= sin_d;
      rr_q     <= rr_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      winner_q <= winner_d;
      cnt_q    <= cnt_d;
      st_q     <= (state_d == TITLE);
      mo_q     <= (state_d == MATCH_END);
    end
  end

  assign du         = du_q;
  assign sin        = sin_q;
  assign st         = st_q;
  assign round_rst  = rr_q;
  assign p1_score   = p1_q;
  assign p2_score   = p2_q;
  assign match_over = mo_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_game_mode_ctrl.sv
// Self-checking bench for game_mode_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural match model.
module tb_game_mode_ctrl;

  localparam int W = 2;
  localparam int H = 4;

  logic        Clk = 1'b0;
  logic        Reset_h;
  logic        VGA_VS;
  logic [15:0] keycode;
  logic        p1win, p2win;
  logic        du, sin, st, round_rst, match_over, winner;
  logic [1:0]  p1_score, p2_score;
  logic [9:0]  dut_v;

  int checks = 0;
  int failures = 0;

  // Model: phase 0 title, 1 fight, 2 round pause, 3 match over; mode 0 none, 1 single, 2 duel.
  int          m_phase, m_mode, m_s1, m_s2, m_cnt;
  logic        m_rr, m_win;
  logic        vh [4];
  logic [15:0] kprev;

  game_mode_ctrl #(
    .WIN_ROUNDS (W),
    .HOLD_FRAMES(H)
  ) dut (
    .Clk       (Clk),
    .Reset_h   (Reset_h),
    .VGA_VS    (VGA_VS),
    .keycode   (keycode),
    .p1win     (p1win),
    .p2win     (p2win),
    .du        (du),
    .sin       (sin),
    .st        (st),
    .round_rst (round_rst),
    .p1_score  (p1_score),
    .p2_score  (p2_score),
    .match_over(match_over),
    .winner    (winner)
  );

  always #5 Clk = ~Clk;

  assign dut_v = {st, du, sin, round_rst, p1_score, p2_score, match_over, winner};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic has(input logic [15:0] kc, input logic [7:0] k);
    return (kc[7:0] == k) || (kc[15:8] == k);
  endfunction

  function automatic logic [9:0] exp_v();
    return {m_phase == 0, m_mode == 2, m_mode == 1, m_rr, 2'(m_s1), 2'(m_s2), m_phase == 3, m_win};
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_mode = 0; m_s1 = 0; m_s2 = 0; m_cnt = 0;
    m_rr = 1'b0; m_win = 1'b0; kprev = '0;
    for (int i = 0; i < 4; i++) vh[i] = 1'b0;
  endfunction

  function automatic void model_step(input logic [15:0] kc, input logic vs, input logic w1, input logic w2);
    logic tick, pS, pD, pE, pX;
    // A frame tick is seen by the sequencer three edges after the VS sample of the rise.
    tick  = vh[2] & ~vh[3];
    vh[3] = vh[2]; vh[2] = vh[1]; vh[1] = vh[0]; vh[0] = vs;
    pS = has(kc, 8'h1E) && !has(kprev, 8'h1E);
    pD = has(kc, 8'h1F) && !has(kprev, 8'h1F);
    pE = has(kc, 8'h28) && !has(kprev, 8'h28);
    pX = has(kc, 8'h29) && !has(kprev, 8'h29);
    kprev = kc;
    m_rr = 1'b0;
    if (m_phase == 0) begin
      if (pS) begin m_mode = 1; m_phase = 1; m_rr = 1'b1; end
      else if (pD) begin m_mode = 2; m_phase = 1; m_rr = 1'b1; end
    end else if (pX) begin
      m_phase = 0; m_mode = 0; m_s1 = 0; m_s2 = 0; m_win = 1'b0;
    end else if (m_phase == 1) begin
      if (w1 || w2) begin
        if (w1 && !w2 && m_s1 < W) m_s1++;
        if (w2 && !w1 && m_s2 < W) m_s2++;
        m_phase = 2; m_cnt = 0;
      end
    end else if (m_phase == 2) begin
      if (tick) begin
        m_cnt++;
        if (m_cnt == H) begin
          if (m_s1 == W || m_s2 == W) begin m_phase = 3; m_win = (m_s2 == W); end
          else begin m_phase = 1; m_rr = 1'b1; end
        end
      end
    end else if (pE) begin
      m_phase = 0; m_mode = 0; m_s1 = 0; m_s2 = 0; m_win = 1'b0;
    end
  endfunction

  task automatic cyc(input logic [15:0] kc, input logic vs, input logic w1, input logic w2);
    keycode = kc; VGA_VS = vs; p1win = w1; p2win = w2;
    @(posedge Clk);
    model_step(kc, vs, w1, w2);
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset_h = 1'b1; keycode = '0; VGA_VS = 1'b0; p1win = 1'b0; p2win = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_h = 1'b0;
    model_reset();
  endtask

  // Drives n frames of VS (high 2, low 2); records round_rst pulses and model disagreements.
  task automatic frames(input int n, output int rr_cnt, output int rr_frame, output int mism);
    rr_cnt = 0; rr_frame = 0; mism = 0;
    for (int f = 1; f <= n; f++) begin
      for (int c = 0; c < 4; c++) begin
        cyc('0, c < 2, 1'b0, 1'b0);
        if (round_rst) begin
          rr_cnt++;
          if (rr_frame == 0) rr_frame = f;
        end
        if (dut_v !== exp_v()) mism++;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_v !== 10'b1000000000) begin
      failures++; $display("FAIL reset_vals: got %b expected %b", dut_v, 10'b1000000000);
    end
  endtask

  task automatic test_duel_select();
    do_reset();
    cyc(16'h1F00, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({du, sin, st, round_rst} !== 4'b1001) begin
      failures++; $display("FAIL duel_press: got du/sin/st/rr=%b expected 1001", {du, sin, st, round_rst});
    end
    cyc('0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({du, sin, st, round_rst} !== 4'b1000) begin
      failures++; $display("FAIL duel_after: got du/sin/st/rr=%b expected 1000", {du, sin, st, round_rst});
    end
  endtask

  task automatic test_single_match();
    int rc, rf, mm;
    do_reset();
    cyc(16'h001E, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({du, sin, st} !== 3'b010) begin
      failures++; $display("FAIL single_mode: got du/sin/st=%b expected 010", {du, sin, st});
    end
    cyc('0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (p1_score !== 2'd1) begin
      failures++; $display("FAIL p1_score_1: got %0d expected 1", p1_score);
    end
    frames(H, rc, rf, mm);
    checks++;
    if (rc != 1 || rf != H || mm != 0) begin
      failures++; $display("FAIL round_hold: got rr_cnt=%0d rr_frame=%0d mism=%0d expected 1 %0d 0", rc, rf, mm, H);
    end
    cyc('0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (p1_score !== 2'd2) begin
      failures++; $display("FAIL p1_score_2: got %0d expected 2", p1_score);
    end
    frames(H, rc, rf, mm);
    checks++;
    if ({match_over, winner, p1_score, p2_score} !== 6'b101000 || rc != 0 || mm != 0) begin
      failures++; $display("FAIL match_end: got mo/win/p1/p2=%b rr_cnt=%0d mism=%0d expected 101000 0 0",
                           {match_over, winner, p1_score, p2_score}, rc, mm);
    end
    cyc(16'h0028, 1'b0, 1'b0, 1'b0);
    checks++;
    if (dut_v !== 10'b1000000000) begin
      failures++; $display("FAIL enter_title: got %b expected %b", dut_v, 10'b1000000000);
    end
  endtask

  task automatic test_draw();
    int rc, rf, mm;
    do_reset();
    cyc(16'h1F00, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({p1_score, p2_score, match_over, st, round_rst} !== 7'b0000000) begin
      failures++; $display("FAIL draw_scores: got p1/p2/mo/st/rr=%b expected 0000000",
                           {p1_score, p2_score, match_over, st, round_rst});
    end
    frames(H, rc, rf, mm);
    checks++;
    if (rc != 1 || rf != H || mm != 0) begin
      failures++; $display("FAIL draw_hold: got rr_cnt=%0d rr_frame=%0d mism=%0d expected 1 %0d 0", rc, rf, mm, H);
    end
  endtask

  task automatic test_hold_key();
    int rr_n, st_fall;
    logic st_prev;
    do_reset();
    rr_n = 0; st_fall = 0; st_prev = st;
    for (int i = 0; i < 50; i++) begin
      cyc((i % 2 == 0) ? 16'h001E : 16'h1E00, 1'b0, 1'b0, 1'b0);
      if (round_rst) rr_n++;
      if (st_prev && !st) st_fall++;
      st_prev = st;
    end
    checks++;
    if (rr_n != 1 || st_fall != 1 || sin !== 1'b1) begin
      failures++; $display("FAIL hold_key: got rr=%0d transitions=%0d sin=%b expected 1 1 1", rr_n, st_fall, sin);
    end
  endtask

  task automatic test_esc_tick();
    int rc, rf, mm, late_rr;
    do_reset();
    cyc(16'h1F00, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b1);
    frames(H - 1, rc, rf, mm);
    checks++;
    if (rc != 0 || mm != 0 || p2_score !== 2'd1) begin
      failures++; $display("FAIL esc_pre: got rr_cnt=%0d mism=%0d p2=%0d expected 0 0 1", rc, mm, p2_score);
    end
    // Final tick of the pause lands on the same edge as the abort press.
    cyc('0, 1'b1, 1'b0, 1'b0);
    cyc('0, 1'b1, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    cyc(16'h2900, 1'b0, 1'b0, 1'b0);
    checks++;
    if (dut_v !== 10'b1000000000) begin
      failures++; $display("FAIL esc_tick: got %b expected %b", dut_v, 10'b1000000000);
    end
    late_rr = 0;
    for (int i = 0; i < 6; i++) begin
      cyc('0, 1'b0, 1'b0, 1'b0);
      if (round_rst || !st) late_rr++;
    end
    checks++;
    if (late_rr != 0) begin
      failures++; $display("FAIL esc_after: got %0d bad cycles expected 0", late_rr);
    end
  endtask

  task automatic test_async_reset();
    int rc, rf, mm;
    do_reset();
    cyc(16'h001E, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b1);
    frames(H, rc, rf, mm);
    cyc('0, 1'b0, 1'b0, 1'b1);
    frames(H, rc, rf, mm);
    checks++;
    if ({match_over, winner, p2_score} !== 4'b1110) begin
      failures++; $display("FAIL p2_match: got mo/win/p2=%b expected 1110", {match_over, winner, p2_score});
    end
    #2 Reset_h = 1'b1;
    #1;
    checks++;
    if (dut_v !== 10'b1000000000) begin
      failures++; $display("FAIL async_reset: got %b expected %b", dut_v, 10'b1000000000);
    end
    @(negedge Clk);
    Reset_h = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    logic [7:0]  keys [8] = '{8'h1E, 8'h1F, 8'h28, 8'h29, 8'h07, 8'h1E, 8'h1F, 8'h28};
    logic [15:0] kc;
    logic        vs, w1, w2;
    do_reset();
    vs = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      kc[7:0]  = ($urandom_range(0, 99) < 92) ? 8'h00 : keys[$urandom_range(0, 7)];
      kc[15:8] = ($urandom_range(0, 99) < 92) ? 8'h00 : keys[$urandom_range(0, 7)];
      if (kc[7:0] == 8'h29 && $urandom_range(0, 3) != 0) kc[7:0] = 8'h00;
      if (kc[15:8] == 8'h29 && $urandom_range(0, 3) != 0) kc[15:8] = 8'h00;
      if ($urandom_range(0, 2) == 0) vs = ~vs;
      w1 = ($urandom_range(0, 99) < 3);
      w2 = ($urandom_range(0, 99) < 3);
      cyc(kc, vs, w1, w2);
      checks++;
      if (dut_v !== exp_v()) begin
        failures++; $display("FAIL random_cycle_%0d: got %b expected %b", i, dut_v, exp_v());
      end
    end
  endtask

  initial begin
    test_reset();
    test_duel_select();
    test_single_match();
    test_draw();
    test_hold_key();
    test_esc_tick();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_mode_ctrl.md
# game_mode_ctrl

Top-level match sequencer for the stick-figure fighting game. It owns the title screen, latches single-player (AI opponent) or duel (second keyboard player) mode, and drives the `du`/`sin`/`st` selects consumed by the player-2 control mux. It also tracks round wins from `p1win`/`p2win`, paces round-end and match-end pauses in video frames, and issues a round restart pulse to the fighter position/animation logic.

## Interface
- `WIN_ROUNDS`, 2: rounds a player must win to take the match (1..3).
- `HOLD_FRAMES`, 120: frames spent in ROUND_END before the next round (1..255).
- `KEY_SINGLE`, 8'h1E: HID code for key '1', which selects single mode.
- `KEY_DUEL`, 8'h1F: HID code for key '2', which selects duel mode.
- `KEY_ENTER`, 8'h28: HID code that acknowledges match end.
- `KEY_ESC`, 8'h29: HID code that aborts to the title screen.

Ports:
- `Clk`  in  1  system clock. One clock domain.
- `Reset_h`  in  1  reset, asynchronous, active-high.
- `VGA_VS`  in  1  vertical sync, asynchronous to the block's logic. Synchronised with 2 flops; a rising edge is one frame tick.
- `keycode`  in  16  two HID key slots, `[7:0]` and `[15:8]`. 8'h00 means empty.
- `p1win`  in  1  level; player 1 has won the current round.
- `p2win`  in  1  level; player 2 has won the current round.
- `du`  out  1  duel mode select.
- `sin`  out  1  single (AI) mode select.
- `st`  out  1  title screen active.
- `round_rst`  out  1  1-cycle pulse that restarts fighter positions and health.
- `p1_score`  out  2  rounds won by player 1.
- `p2_score`  out  2  rounds won by player 2.
- `match_over`  out  1  high in MATCH_END.
- `winner`  out  1  0 = player 1, 1 = player 2. Valid while `match_over` is high.

## Operation
- A key "press" for code K is a cycle where K is present in either slot and was absent in both slots the previous cycle. This is tracked with one registered present flag per code.
- The FSM has four states: TITLE, FIGHT, ROUND_END, MATCH_END.
- TITLE:
  - `st`=1; `du`=`sin`=0; scores held at 0.
  - Press of KEY_SINGLE: set `sin`, go to FIGHT, pulse `round_rst`.
  - Press of KEY_DUEL: set `du`, go to FIGHT, pulse `round_rst`.
  - Both pressed in the same cycle: KEY_SINGLE wins.
- FIGHT:
  - Mode is held.
  - `p1win` alone: `p1_score`+1, go to ROUND_END.
  - `p2win` alone: `p2_score`+1, go to ROUND_END.
  - Both in the same cycle: draw. No score change; go to ROUND_END.
- ROUND_END:
  - Counts frame ticks. At tick number HOLD_FRAMES, if either score equals WIN_ROUNDS, go to MATCH_END and set `winner`.
  - Otherwise pulse `round_rst` and return to FIGHT.
  - `p1win`/`p2win` are ignored in this state.
- MATCH_END:
  - `match_over`=1; scores and mode are held.
  - Press of KEY_ENTER: go to TITLE, clear scores, `du`=`sin`=0.
- KEY_ESC press in FIGHT, ROUND_END or MATCH_END: go to TITLE immediately and clear everything. This takes priority over any other event in the same cycle.
- Scores saturate at WIN_ROUNDS. `du` and `sin` are never both 1.
- All outputs are registered.

## Timing
- Reset values: state=TITLE, `st`=1, `du`=`sin`=0, `round_rst`=0, scores=0, `match_over`=0, `winner`=0. Frame counter and key flags are cleared.
- Reset asserted mid-match returns to these values asynchronously.
- Key press to mode change: `du`/`sin`, `st` and `round_rst` update 1 cycle after the press cycle (registered edge detect plus registered FSM output).
- `p1win`/`p2win` in FIGHT: score and state update on the next clock edge.
- Frame tick:
  - Appears 3 `Clk` cycles after the `VGA_VS` rise (2 sync flops plus the edge register).
  - Is exactly 1 cycle wide.
  - The ROUND_END frame counter is cleared on entry.
- ROUND_END lasts exactly HOLD_FRAMES ticks. `round_rst` fires in the cycle after the HOLD_FRAMES-th tick is detected. The FIGHT state is entered together with `round_rst`.
- A `p1win` level still high when FIGHT is re-entered scores again. Downstream logic must clear the win on `round_rst`.

## Test plan
- Reset, then press 8'h1F in slot `[15:8]`: `du`=1, `sin`=0, `st`=0, and `round_rst` high for exactly one cycle.
- Single mode with HOLD_FRAMES=4 and WIN_ROUNDS=2:
  - Pulse `p1win` twice, with 4 VGA_VS rises between them.
  - Required: `p1_score` goes 1 then 2; `match_over`=1; `winner`=0.
  - Press 8'h28: TITLE, scores 0, `st`=1.
- Raise `p1win` and `p2win` in the same cycle during FIGHT: scores unchanged, ROUND_END entered, `round_rst` after 4 frame ticks.
- Hold key 8'h1E for 50 cycles with no release in TITLE: exactly one transition and one `round_rst` pulse.
- Press 8'h29 during ROUND_END while a frame tick arrives in the same cycle: TITLE, `du`=`sin`=0, no `round_rst`.
- Assert `Reset_h` asynchronously in MATCH_END between clock edges: all outputs take their reset values before the next `Clk` edge.
